andor_sweep_driver: RTL and testbench

ANDOR_SWEEP_DRIVER -- requirements
Module: andor_sweep_driver

---
 rtl/andor_sweep_driver.sv | 131 +++++++++++++
 tb/tb_andor_sweep_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/andor_sweep_driver.sv
// andor_sweep_driver: exhaustive stimulus sweep for a dual AND-OR gate
// (one 3-3 AND-OR, one 2-2 AND-OR). Walks all 1024 input combinations,
// waits SAMPLE_DELAY settle cycles per vector, then compares the returned
// gate outputs with the ideal function and accumulates mismatch results.
module andor_sweep_driver #(
    parameter int unsigned SAMPLE_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [5:0]  drv_p1,
    output logic [3:0]  drv_p2,
    input  logic        dut_p1y,
    input  logic        dut_p2y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count,
    output logic [9:0]  first_err_vec,
    output logic        first_err_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SAMPLE_DELAY - 1);
    localparam logic [9:0] VEC_LAST  = 10'h3FF;

    state_t      state, state_nxt;
    logic [9:0]  vec;
    logic [3:0]  wcnt;
    logic [10:0] err_q;
    logic [9:0]  fev_q;
    logic        fev_vld_q;

    logic exp1, exp2, mismatch;
    logic in_busy, in_rest, accept, kill, wait_end;

    // Ideal gate responses for the vector currently on the drive pins
    assign exp1     = (&vec[2:0]) | (&vec[5:3]);
    assign exp2     = (&vec[7:6]) | (&vec[9:8]);
    assign mismatch = (dut_p1y != exp1) || (dut_p2y != exp2);

    assign in_busy  = (state == S_WAIT) || (state == S_CHECK);
    assign in_rest  = (state == S_IDLE) || (state == S_DONE);
    // abort beats start when both arrive while at rest
    assign accept   = in_rest && start && !abort;
    assign kill     = in_busy && abort;
    assign wait_end = (wcnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides the compare step
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start && abort) state_nxt = S_IDLE;
                else if (start)     state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (abort)         state_nxt = S_IDLE;
                else if (wait_end) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (vec == VEC_LAST)  state_nxt = S_DONE;
                else                       state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = in_busy;
        done = (state == S_DONE);
        pass = (state == S_DONE) && (err_q == '0);
    end

    // Settle counter: restarts at zero for every newly driven vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           wcnt <= '0;
        else if (accept || kill)              wcnt <= '0;
        else if (state == S_WAIT && !abort)   wcnt <= wait_end ? 4'd0 : wcnt + 4'd1;
    end

    // Vector register and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            err_q     <= '0;
            fev_q     <= '0;
            fev_vld_q <= 1'b0;
        end else if (accept) begin
            vec       <= '0;
            err_q     <= '0;
            fev_q     <= '0;
            fev_vld_q <= 1'b0;
        end else if (kill) begin
            // partial results stay visible after a cancelled sweep
            vec <= '0;
        end else if (state == S_CHECK) begin
            if (mismatch) begin
                err_q <= err_q + 11'd1;
                if (!fev_vld_q) begin
                    fev_q     <= vec;
                    fev_vld_q <= 1'b1;
                end
            end
            // last vector stays on the pins through DONE
            if (vec != VEC_LAST) vec <= vec + 10'd1;
        end
    end

    assign drv_p1          = vec[5:0];
    assign drv_p2          = vec[9:6];
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fev_vld_q;

endmodule

// File: tb/tb_andor_sweep_driver.sv
// Scoreboard bench: two sweepers (SAMPLE_DELAY 1 and 3), each closing the
// loop through a behavioural gate model with selectable faults.
// Stimulus pushes the expected end-of-sweep result; the monitor pops and
// compares it whenever a sweeper raises done.
module tb_andor_sweep_driver;

    typedef struct {
        int err;
        int pass;
        int fv;
        int fev;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = '0;
    logic [1:0]  abort = '0;
    logic [5:0]  p1 [2];
    logic [3:0]  p2 [2];
    logic [1:0]  y1, y2;
    logic [1:0]  busy, done, pass, fvld;
    logic [10:0] errc [2];
    logic [9:0]  fev [2];

    // 0: good gate, 1: p1y stuck at 0, 2: p1y/p2y swapped
    int mode [2] = '{0, 0};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   mark [2] = '{0, 0};
    logic [1:0] busy_d = '0, done_d = '0;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    andor_sweep_driver #(.SAMPLE_DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .drv_p1(p1[0]), .drv_p2(p2[0]), .dut_p1y(y1[0]), .dut_p2y(y2[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .first_err_vec(fev[0]), .first_err_valid(fvld[0])
    );

    andor_sweep_driver #(.SAMPLE_DELAY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .drv_p1(p1[1]), .drv_p2(p2[1]), .dut_p1y(y1[1]), .dut_p2y(y2[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
        .first_err_vec(fev[1]), .first_err_valid(fvld[1])
    );

    // Behavioural gate under test with fault injection
    always_comb begin
        y1 = '0;
        y2 = '0;
        for (int i = 0; i < 2; i++) begin
            logic g1, g2;
            g1 = (p1[i][0] & p1[i][1] & p1[i][2]) | (p1[i][3] & p1[i][4] & p1[i][5]);
            g2 = (p2[i][0] & p2[i][1]) | (p2[i][2] & p2[i][3]);
            y1[i] = (mode[i] == 1) ? 1'b0 : (mode[i] == 2) ? g2 : g1;
            y2[i] = (mode[i] == 2) ? g1 : g2;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: on each rising done, compare against the oldest expectation
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] && !busy_d[i]) mark[i] = cyc;
            if (done[i] && !done_d[i]) begin
                exp_t e;
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    chk($sformatf("unexpected_done_d%0d", i), 1, 0);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("d%0d_err_count", i), int'(errc[i]), e.err);
                    chk($sformatf("d%0d_pass", i), int'(pass[i]), e.pass);
                    chk($sformatf("d%0d_first_err_valid", i), int'(fvld[i]), e.fv);
                    chk($sformatf("d%0d_first_err_vec", i), int'(fev[i]), e.fev);
                    chk($sformatf("d%0d_sweep_cycles", i), cyc - mark[i], e.cyc);
                    chk($sformatf("d%0d_drive_last", i), int'({p2[i], p1[i]}), 1023);
                end
            end
        end
        busy_d = busy;
        done_d = done;
    end

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start = '0;
    endtask

    task automatic wait_done(input int i, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done[i]) break;
        end
        if (k == bound) chk($sformatf("d%0d_done_timeout", i), 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_drive"}, int'({p2[0], p1[0]}), 0);
        chk({tag, "_busy"}, int'(busy[0]), 0);
        chk({tag, "_done"}, int'(done[0]), 0);
        chk({tag, "_pass"}, int'(pass[0]), 0);
        chk({tag, "_err"}, int'(errc[0]), 0);
        chk({tag, "_fev"}, int'(fev[0]), 0);
        chk({tag, "_fvld"}, int'(fvld[0]), 0);
    endtask

    initial begin
        int k;
        bit busy_ok;

        // Reset state
        #2;
        chk_zero("reset");
        chk("reset_d3_busy", int'(busy[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good gate: 2048-cycle sweep, clean result
        mode[0] = 0;
        q0.push_back('{err: 0, pass: 1, fv: 0, fev: 0, cyc: 2048});
        pulse_start(0);
        wait_done(0, 2200);

        // p1y stuck at 0: vectors with a full 3-AND on gate 1 -> 15*16 = 240
        mode[0] = 1;
        q0.push_back('{err: 240, pass: 0, fv: 1, fev: 7, cyc: 2048});
        pulse_start(0);
        wait_done(0, 2200);

        // swapped outputs: exp1!=exp2 -> 15*9 + 49*7 = 478, first at 0x007
        mode[0] = 2;
        q0.push_back('{err: 478, pass: 0, fv: 1, fev: 7, cyc: 2048});
        pulse_start(0);
        wait_done(0, 2200);

        // SAMPLE_DELAY=3: 4096 cycles, busy held, mid-sweep starts ignored
        mode[1] = 0;
        q1.push_back('{err: 0, pass: 1, fv: 0, fev: 0, cyc: 4096});
        pulse_start(1);
        busy_ok = 1'b1;
        for (k = 0; k < 4300; k++) begin
            @(negedge clk);
            if (done[1]) break;
            if (!busy[1]) busy_ok = 1'b0;
            start[1] = ((k % 1000) == 500);
        end
        start = '0;
        if (k == 4300) chk("d1_done_timeout", 0, 1);
        chk("d1_busy_throughout", int'(busy_ok), 1);

        // Abort at vec=100, stuck-at-0: vectors 0..99 checked.
        // 0..63 give 15, 64..99 give 71,79,87,95 -> 19 partial errors
        mode[0] = 1;
        pulse_start(0);
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if ({p2[0], p1[0]} == 10'd100) break;
        end
        if (k == 400) chk("abort_vec100_timeout", 0, 1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort = '0;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        chk("abort_drive", int'({p2[0], p1[0]}), 0);
        chk("abort_err_partial", int'(errc[0]), 19);
        chk("abort_fev", int'(fev[0]), 7);
        repeat (3) @(negedge clk);
        chk("abort_idle_stays", int'(busy[0]), 0);

        // Fresh full sweep after the abort
        q0.push_back('{err: 240, pass: 0, fv: 1, fev: 7, cyc: 2048});
        pulse_start(0);
        wait_done(0, 2200);

        // abort alone in DONE: no effect
        @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort = '0;
        chk("done_abort_done", int'(done[0]), 1);
        // start+abort in DONE: go idle, nothing cleared
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        start = '0;
        abort = '0;
        chk("startabort_done", int'(done[0]), 0);
        chk("startabort_busy", int'(busy[0]), 0);
        chk("startabort_err", int'(errc[0]), 240);
        chk("startabort_fvld", int'(fvld[0]), 1);

        // Asynchronous reset mid-sweep
        mode[0] = 0;
        pulse_start(0);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        q0.push_back('{err: 0, pass: 1, fv: 0, fev: 0, cyc: 2048});
        pulse_start(0);
        wait_done(0, 2200);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
